lsu_split_access: RTL and testbench

Load/store initiator sitting between the execute stage and data_memory.
- Accepts one load or store request at a time from the pipeline over a valid/ready handshake.
- Drives the data_memory port: write_enable, mem_width, addr, write_data, read_data.
- Aligned accesses go out as a single memory access.
- Misaligned halfword/word accesses are split into sequential byte accesses. Load results are reassembled and sign/zero-extended before the response is returned.

---
 rtl/lsu_split_access.sv | 168 ++++++++++++++++
 tb/tb_lsu_split_access.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_split_access.sv
// Load/store initiator between execute and data memory. Aligned accesses go out as one
// memory cycle; misaligned half/word accesses are split into byte accesses or rejected.
module lsu_split_access #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_width,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_write_enable,
  output logic [2:0]  mem_width,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {StIdle, StAccess, StSplit, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] result_q, result_d;
  logic        error_q, error_d;
  logic        split_q, split_d;
  logic        write_q;
  logic [2:0]  width_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic accept;
  logic illegal;
  logic misaligned;
  logic last_byte;

  assign req_ready = (state_q == StIdle) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    illegal    = (req_width == 3'b011) || (req_width == 3'b110) || (req_width == 3'b111);
    misaligned = 1'b0;
    unique case (req_width[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Halfword splits end at k=1, word splits at k=3.
  assign last_byte = width_q[1] ? (k_q == 2'd3) : (k_q == 2'd1);

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    result_d = result_q;
    error_d  = error_q;
    split_d  = split_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          result_d = '0;
          k_d      = '0;
          error_d  = 1'b0;
          split_d  = 1'b0;
          if (illegal) begin
            error_d = 1'b1;
            state_d = StDone;
          end else if (!misaligned) begin
            state_d = StAccess;
          end else if (SPLIT_EN) begin
            split_d = 1'b1;
            state_d = StSplit;
          end else begin
            error_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StAccess: begin
        if (!write_q) result_d = mem_read_data;
        state_d = StDone;
      end
      StSplit: begin
        if (!write_q) result_d[{k_q, 3'b000} +: 8] = mem_read_data[7:0];
        k_d = k_q + 2'd1;
        if (last_byte) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      k_q      <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      split_q  <= 1'b0;
      write_q  <= 1'b0;
      width_q  <= 3'b010;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      result_q <= result_d;
      error_q  <= error_d;
      split_q  <= split_d;
      if (accept) begin
        write_q <= req_write;
        width_q <= req_width;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Memory drive is forced to idle during reset so a reset edge can never commit a write.
  always_comb begin
    mem_write_enable = 1'b0;
    mem_width        = 3'b010;
    mem_addr         = '0;
    mem_write_data   = '0;
    if (!reset) begin
      unique case (state_q)
        StAccess: begin
          mem_write_enable = write_q;
          mem_width        = width_q;
          mem_addr         = addr_q;
          mem_write_data   = wdata_q;
        end
        StSplit: begin
          mem_write_enable = write_q;
          mem_width        = write_q ? 3'b000 : 3'b100;
          mem_addr         = addr_q + {30'b0, k_q};
          mem_write_data   = {24'b0, wdata_q[{k_q, 3'b000} +: 8]};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    resp_valid = (state_q == StDone) && !reset;
    resp_error = resp_valid && error_q;
    resp_rdata = '0;
    if (resp_valid && !error_q && !write_q) begin
      if (split_q) begin
        unique case (width_q)
          3'b001:  resp_rdata = {{16{result_q[15]}}, result_q[15:0]};
          3'b101:  resp_rdata = {16'b0, result_q[15:0]};
          default: resp_rdata = result_q;
        endcase
      end else begin
        resp_rdata = result_q;
      end
    end
  end

endmodule

// File: tb/tb_lsu_split_access.sv
// Scoreboard bench for lsu_split_access: a byte-array memory model, expected responses
// and memory writes queued at issue time, and negedge monitors that pop and compare.
module tb_lsu_split_access;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [2:0]  mem_width;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        req_valid1, req_ready1, req_write1;
  logic [2:0]  req_width1;
  logic [31:0] req_addr1, req_wdata1;
  logic        resp_valid1, resp_error1;
  logic [31:0] resp_rdata1;
  logic        mem_we1;
  logic [2:0]  mem_width1;
  logic [31:0] mem_addr1, mem_wdata1;
  logic [31:0] mem_rdata1 = 32'h0;

  lsu_split_access #(.SPLIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_write_enable(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
    .mem_write_data(mem_wdata), .mem_read_data(mem_rdata)
  );

  lsu_split_access #(.SPLIT_EN(1'b0)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_width(req_width1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_error(resp_error1),
    .mem_write_enable(mem_we1), .mem_width(mem_width1), .mem_addr(mem_addr1),
    .mem_write_data(mem_wdata1), .mem_read_data(mem_rdata1)
  );

  // Memory model: 256 bytes indexed by addr[7:0], little-endian, extending like data_memory.
  logic [7:0] tbmem [256];
  logic       mem_clr;
  logic [7:0] wa;
  assign wa = mem_addr[7:0];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) tbmem[i] <= 8'h00;
    end else if (mem_we) begin
      tbmem[wa] <= mem_wdata[7:0];
      if (mem_width[1:0] != 2'b00) tbmem[wa + 8'd1] <= mem_wdata[15:8];
      if (mem_width[1]) begin
        tbmem[wa + 8'd2] <= mem_wdata[23:16];
        tbmem[wa + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = tbmem[wa];
    b1 = tbmem[wa + 8'd1];
    b2 = tbmem[wa + 8'd2];
    b3 = tbmem[wa + 8'd3];
    case (mem_width)
      3'b000:  mem_rdata = {{24{b0[7]}}, b0};
      3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b100:  mem_rdata = {24'b0, b0};
      3'b101:  mem_rdata = {16'b0, b1, b0};
      default: mem_rdata = {b3, b2, b1, b0};
    endcase
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  width;
    logic [31:0] data;
  } wr_t;

  resp_t rq[$];
  resp_t rq1[$];
  wr_t   wq[$];

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_errs = 0;
  int wr1_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    resp_t e;
    wr_t   w;
    if (resp_valid) begin
      if (rq.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = rq.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_error", 32'(resp_error), 32'(e.err));
        check("resp_latency", cyc, e.cyc);
      end
    end
    if (mem_we) begin
      if (wq.size() == 0) begin
        check("unexpected_write", mem_addr, 32'hxxxx_xxxx);
      end else begin
        w = wq.pop_front();
        check("wr_addr", mem_addr, w.addr);
        check("wr_width", 32'(mem_width), 32'(w.width));
        check("wr_data", mem_wdata, w.data);
      end
    end
  end

  always @(negedge clk) begin
    resp_t e;
    if (mem_we1) wr1_cnt++;
    if (resp_valid1) begin
      if (rq1.size() == 0) begin
        check("dut1_unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = rq1.pop_front();
        check("dut1_rdata", resp_rdata1, e.rdata);
        check("dut1_error", 32'(resp_error1), 32'(e.err));
        check("dut1_latency", cyc, e.cyc);
      end
    end
  end

  task automatic exp_wr(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d);
    wq.push_back('{a, w, d});
  endtask

  // lat < 0: no response expected. Request fields are scrambled after accept.
  task automatic issue(input bit sel, input bit wr, input bit [2:0] w, input bit [31:0] a,
                       input bit [31:0] d, input bit [31:0] er, input bit ee, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!(sel ? req_ready1 : req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(sel ? req_ready1 : req_ready), 32'd1);
    if (lat >= 0) begin
      if (sel) rq1.push_back('{er, ee, cyc + 32'(lat)});
      else     rq.push_back('{er, ee, cyc + 32'(lat)});
    end
    if (sel) begin
      req_valid1 = 1'b1; req_write1 = wr; req_width1 = w; req_addr1 = a; req_wdata1 = d;
    end else begin
      req_valid = 1'b1; req_write = wr; req_width = w; req_addr = a; req_wdata = d;
    end
    @(posedge clk);
    #1;
    if (sel) begin
      req_valid1 = 1'b0; req_write1 = ~wr; req_width1 = 3'b110; req_addr1 = ~a;
      req_wdata1 = ~d;
    end else begin
      req_valid = 1'b0; req_write = ~wr; req_width = 3'b110; req_addr = ~a; req_wdata = ~d;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() + rq1.size() + wq.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(rq.size() + rq1.size() + wq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; mem_clr = 1'b1;
    req_valid = 0; req_write = 0; req_width = 3'b010; req_addr = 0; req_wdata = 0;
    req_valid1 = 0; req_write1 = 0; req_width1 = 3'b010; req_addr1 = 0; req_wdata1 = 0;
    repeat (3) @(posedge clk);
    #1 req_valid = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_width", 32'(mem_width), 32'd2);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0; mem_clr = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_ready1", 32'(req_ready1), 32'd1);
    check("post_rst_no_resp", 32'(resp_valid), 32'd0);

    // Aligned word store then loads of every legal width.
    exp_wr(32'h10, 3'b010, 32'hF0F0_F0F0);
    issue(0, 1, 3'b010, 32'h10, 32'hF0F0_F0F0, 32'h0, 0, 2);
    drain();
    issue(0, 0, 3'b010, 32'h10, 32'h0, 32'hF0F0_F0F0, 0, 2); drain();
    issue(0, 0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFF0, 0, 2); drain();
    issue(0, 0, 3'b001, 32'h10, 32'h0, 32'hFFFF_F0F0, 0, 2); drain();
    issue(0, 0, 3'b100, 32'h10, 32'h0, 32'h0000_00F0, 0, 2); drain();
    issue(0, 0, 3'b101, 32'h10, 32'h0, 32'h0000_F0F0, 0, 2); drain();

    // Misaligned word store split into four bytes, then split load back.
    exp_wr(32'h41, 3'b000, 32'h89);
    exp_wr(32'h42, 3'b000, 32'h67);
    exp_wr(32'h43, 3'b000, 32'h45);
    exp_wr(32'h44, 3'b000, 32'h23);
    issue(0, 1, 3'b010, 32'h41, 32'h2345_6789, 32'h0, 0, 5); drain();
    issue(0, 0, 3'b010, 32'h41, 32'h0, 32'h2345_6789, 0, 5); drain();

    // Misaligned halfword: store F0F0, signed and unsigned loads, then a positive value.
    exp_wr(32'h43, 3'b000, 32'hF0);
    exp_wr(32'h44, 3'b000, 32'hF0);
    issue(0, 1, 3'b001, 32'h43, 32'hDEAD_F0F0, 32'h0, 0, 3); drain();
    issue(0, 0, 3'b001, 32'h43, 32'h0, 32'hFFFF_F0F0, 0, 3); drain();
    issue(0, 0, 3'b101, 32'h43, 32'h0, 32'h0000_F0F0, 0, 3); drain();
    exp_wr(32'h43, 3'b000, 32'h0F);
    exp_wr(32'h44, 3'b000, 32'h0F);
    issue(0, 1, 3'b001, 32'h43, 32'h1234_0F0F, 32'h0, 0, 3); drain();
    issue(0, 0, 3'b001, 32'h43, 32'h0, 32'h0000_0F0F, 0, 3); drain();

    // Illegal widths: error after one cycle, no memory access.
    issue(0, 1, 3'b011, 32'h20, 32'h55, 32'h0, 1, 1); drain();
    issue(0, 0, 3'b111, 32'h10, 32'h0, 32'h0, 1, 1); drain();
    check("illegal_mem_unchanged", 32'(tbmem[8'h20]), 32'h0);

    // Address wrap across the top of memory.
    exp_wr(32'hFFFF_FFFE, 3'b000, 32'h44);
    exp_wr(32'hFFFF_FFFF, 3'b000, 32'h33);
    exp_wr(32'h0000_0000, 3'b000, 32'h22);
    exp_wr(32'h0000_0001, 3'b000, 32'h11);
    issue(0, 1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 32'h0, 0, 5); drain();
    issue(0, 0, 3'b010, 32'hFFFF_FFFE, 32'h0, 32'h1122_3344, 0, 5); drain();

    // SPLIT_EN=0: misaligned accesses are rejected without touching memory.
    issue(1, 1, 3'b010, 32'h41, 32'h99, 32'h0, 1, 1); drain();
    issue(1, 0, 3'b001, 32'h43, 32'h0, 32'h0, 1, 1); drain();
    check("dut1_no_writes", 32'(wr1_cnt), 32'd0);

    // Reset after the second byte of a split store.
    exp_wr(32'h81, 3'b000, 32'hDD);
    exp_wr(32'h82, 3'b000, 32'hCC);
    issue(0, 1, 3'b010, 32'h81, 32'hAABB_CCDD, 32'h0, 0, -1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    drain();
    check("midrst_b0", 32'(tbmem[8'h81]), 32'hDD);
    check("midrst_b1", 32'(tbmem[8'h82]), 32'hCC);
    check("midrst_b2", 32'(tbmem[8'h83]), 32'h00);
    check("midrst_b3", 32'(tbmem[8'h84]), 32'h00);

    // Unit still works after the interrupted split.
    issue(0, 0, 3'b100, 32'h82, 32'h0, 32'h0000_00CC, 0, 2); drain();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
